// File: rtl/clip_obj_fetcher.sv
// clip_obj_fetcher: scans video-memory object slots and presents unpacked objects to the clipper
module clip_obj_fetcher #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 144
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   obj_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] clip_addr,
  output logic              clip_rd_en,
  input  logic [DATA_W-1:0] clip_obj_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_x0,
  output logic [15:0]       out_y0,
  output logic [15:0]       out_x1,
  output logic [15:0]       out_y1,
  output logic [15:0]       out_x2,
  output logic [15:0]       out_y2,
  output logic [15:0]       out_x3,
  output logic [15:0]       out_y3,
  output logic [11:0]       out_color,
  output logic [3:0]        out_obj_type,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  typedef enum logic [1:0] {IDLE, READ, CAPT, PRES} state_t;
  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_obj;
  logic [ADDR_W:0]   w_cnt;
  logic              w_last;
  assign w_cnt = (obj_count > DEPTH) ? DEPTH : obj_count;
  assign w_last = {1'b0, r_idx} == r_cnt - 1'b1;
  assign {out_obj_type, out_color, out_y3, out_x3, out_y2, out_x2, out_y1, out_x1, out_y0, out_x0} = r_obj;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_obj      <= '0;
      clip_addr  <= '0;
      clip_rd_en <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && r_state != IDLE) begin
        r_state    <= IDLE;
        clip_rd_en <= 1'b0;
        out_valid  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_cnt <= w_cnt;
            r_idx <= '0;
            done  <= w_cnt == '0;
            if (w_cnt != '0) begin
              r_state    <= READ;
              clip_rd_en <= 1'b1;
              clip_addr  <= '0;
              busy       <= 1'b1;
            end
          end
          READ: begin
            clip_rd_en <= 1'b0;
            r_state    <= CAPT;
          end
          CAPT: begin
            r_obj     <= clip_obj_in;
            out_idx   <= r_idx;
            out_valid <= 1'b1;
            r_state   <= PRES;
          end
          PRES: if (out_ready) begin
            out_valid <= 1'b0;
            if (w_last) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx      <= r_idx + 1'b1;
              clip_addr  <= r_idx + 1'b1;
              clip_rd_en <= 1'b1;
              r_state    <= READ;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clip_obj_fetcher.sv
// tb_clip_obj_fetcher: randomized scans checked against an expected-beat queue built from memory contents
module tb_clip_obj_fetcher;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   obj_count = '0;
  logic         abort = 1'b0;
  logic [4:0]   clip_addr;
  logic         clip_rd_en;
  logic [143:0] clip_obj_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_x0, out_y0, out_x1, out_y1, out_x2, out_y2, out_x3, out_y3;
  logic [11:0]  out_color;
  logic [3:0]   out_obj_type;
  logic [4:0]   out_idx;
  logic         busy, done;
  logic [143:0] mem [32];
  logic [148:0] exp_q [$];
  logic [143:0] got [32];
  logic [143:0] w_obj, prev_obj;
  logic [4:0]   prev_idx;
  logic         prev_valid = 1'b0, prev_hs = 1'b0;
  int pass = 0, total = 0;
  int exp_rd = 0, outstanding = 0, strobes = 0, beats = 0, dones = 0;
  clip_obj_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .obj_count(obj_count), .abort(abort),
    .clip_addr(clip_addr), .clip_rd_en(clip_rd_en), .clip_obj_in(clip_obj_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_y0(out_y0), .out_x1(out_x1), .out_y1(out_y1),
    .out_x2(out_x2), .out_y2(out_y2), .out_x3(out_x3), .out_y3(out_y3),
    .out_color(out_color), .out_obj_type(out_obj_type), .out_idx(out_idx),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (clip_rd_en) clip_obj_in <= mem[clip_addr];
  assign w_obj = {out_obj_type, out_color, out_y3, out_x3, out_y2, out_x2, out_y1, out_x1, out_y0, out_x0};
  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (clip_rd_en) begin
        chk("rd_addr", clip_addr, exp_rd);
        chk("rd_single_outstanding", outstanding, 0);
        exp_rd++;
        outstanding = 1;
        strobes++;
      end
      if (out_valid && prev_valid && !prev_hs) chk("hold_stable", {out_idx, w_obj}, {prev_idx, prev_obj});
      prev_hs = out_valid && out_ready && !abort;
      if (prev_hs) begin
        if (exp_q.size() == 0) chk("beat_extra", 1, 0);
        else chk("beat", {out_idx, w_obj}, exp_q.pop_front());
        got[out_idx] = w_obj;
        outstanding = 0;
        beats++;
      end
      if (done) begin
        dones++;
        chk("done_busy_low", busy, 0);
        chk("done_all_beats", exp_q.size(), 0);
      end
      prev_valid = out_valid;
      prev_obj = w_obj;
      prev_idx = out_idx;
    end
  end
  task automatic do_start(input int cnt);
    int c;
    c = cnt > 32 ? 32 : cnt;
    exp_q.delete();
    for (int k = 0; k < c; k++) exp_q.push_back({5'(k), mem[k]});
    exp_rd = 0;
    outstanding = 0;
    obj_count = 6'(cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input bit rnd, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", done, 1);
  endtask
  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_seen", out_valid, 1);
  endtask
  task automatic rand_mem();
    for (int k = 0; k < 32; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, {clip_addr, clip_rd_en, out_valid, out_idx, busy, done, w_obj}, '0);
  endtask
  initial begin
    int cyc, b0, s0, d0;
    logic [143:0] w;
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < 8; i++) mem[k][16*i +: 16] = 16'(k * 16 + i);
      mem[k][139:128] = 12'hA00 + 12'(k);
      mem[k][143:140] = 4'(k);
    end
    #3 chk_zero("reset_outputs");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    s0 = strobes; b0 = beats; d0 = dones;
    do_start(3);
    chk("rd_latency", {clip_rd_en, clip_addr, busy}, {1'b1, 5'd0, 1'b1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("valid_latency", {out_valid, out_idx}, {1'b1, 5'd0});
    wait_done(100, 0, cyc);
    chk("start_to_done_edges", cyc + 2, 9);
    chk("t1_strobes", strobes - s0, 3);
    chk("t1_beats", beats - b0, 3);
    @(posedge clk); #1;
    chk("t1_one_done", dones - d0, 1);
    w = got[1];
    chk("slot1_x0", w[15:0], 16'h0010);
    chk("slot1_y3", w[127:112], 16'h0017);
    chk("slot1_color", w[139:128], 12'hA01);
    chk("slot1_type", w[143:140], 4'h1);
    out_ready = 1'b0;
    s0 = strobes;
    do_start(2);
    wait_valid(20);
    repeat (5) begin @(posedge clk); #1; end
    chk("t2_hold_valid", {out_valid, out_idx}, {1'b1, 5'd0});
    chk("t2_no_second_read", strobes - s0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_after_hs", {out_valid, clip_rd_en, clip_addr}, {1'b0, 1'b1, 5'd1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_slot1_follows", {out_valid, out_idx}, {1'b1, 5'd1});
    wait_done(50, 0, cyc);
    @(posedge clk); #1;
    s0 = strobes; d0 = dones;
    do_start(0);
    chk("t3_done_next", {done, busy, clip_rd_en}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("t3_done_pulse", {done, busy}, 2'b00);
    chk("t3_no_reads", strobes - s0, 0);
    rand_mem();
    s0 = strobes; b0 = beats; d0 = dones;
    do_start(40);
    wait_done(3000, 1, cyc);
    @(posedge clk); #1;
    chk("t4_beats_32", beats - b0, 32);
    chk("t4_strobes_32", strobes - s0, 32);
    chk("t4_one_done", dones - d0, 1);
    out_ready = 1'b1;
    b0 = beats; d0 = dones;
    do_start(5);
    cyc = 0;
    while (!(clip_rd_en && clip_addr == 5'd2) && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_idle", {out_valid, busy, clip_rd_en}, 3'b000);
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_no_done", dones - d0, 0);
    chk("t5_beats_before_abort", beats - b0, 2);
    b0 = beats;
    do_start(2);
    wait_done(50, 0, cyc);
    chk("t5_rescan_beats", beats - b0, 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    b0 = beats; d0 = dones;
    do_start(3);
    wait_valid(20);
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_beats_hs", {out_valid, busy, 32'(beats - b0)}, '0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_hs_no_done", dones - d0, 0);
    b0 = beats; s0 = strobes; d0 = dones;
    do_start(4);
    repeat (4) begin @(posedge clk); #1; end
    obj_count = 6'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, 0, cyc);
    @(posedge clk); #1;
    chk("t6_busy_start_beats", beats - b0, 4);
    chk("t6_busy_start_strobes", strobes - s0, 4);
    chk("t6_one_done", dones - d0, 1);
    out_ready = 1'b0;
    do_start(3);
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset_mid_pres");
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    for (int r = 0; r < 8; r++) begin
      int c;
      rand_mem();
      c = (r == 7) ? 33 + int'($urandom_range(0, 30)) : int'($urandom_range(1, 10));
      b0 = beats; d0 = dones;
      do_start(c);
      wait_done(3000, 1, cyc);
      @(posedge clk); #1;
      chk("rand_beats", beats - b0, c > 32 ? 32 : c);
      chk("rand_one_done", dones - d0, 1);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
